// File: rtl/vec_writeback.sv
// vec_writeback: writes vector result beats into a register file.
// Beats arrive on a valid/ready handshake, optionally as bursts of up to four
// beats targeting consecutive registers. Each beat is written in its own
// WRITE slot. A partial lane mask turns the beat into a read-modify-write
// through a READ slot. Register 0 and all-zero masks are dropped quietly.
// Targets past the last register are dropped and flagged with err.
//
// Optional feature: define VWB_LANE_MASK_EN to enable lane-masked
// read-modify-write. Without it wb_mask is ignored, every beat is a full write,
// and the read port is tied off.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   wb_valid/wb_ready   beat handshake; ready is low in READ and during reset
//   wb_addr, wb_len     burst base register and length-1 (first beat only)
//   wb_data, wb_mask    beat payload and per-lane write mask
//   rf_rd_addr/en/data  register file read port (data is combinational)
//   rf_wr_addr/en/data  register file write port
//   done                pulse in the write slot of a burst's final beat
//   err                 pulse in the write slot of an out-of-range beat
module vec_writeback #(
  parameter int Registerlength = 64,
  parameter int numRegisters   = 8,
  parameter int AddressLength  = $clog2(numRegisters),
  parameter int elementSize    = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     wb_valid,
  output logic                                     wb_ready,
  input  logic [AddressLength-1:0]                 wb_addr,
  input  logic [1:0]                               wb_len,
  input  logic [Registerlength-1:0]                wb_data,
  input  logic [Registerlength/elementSize-1:0]    wb_mask,
  output logic [AddressLength-1:0]                 rf_rd_addr,
  output logic [Registerlength/elementSize-1:0]    rf_rd_en,
  input  logic [Registerlength-1:0]                rf_rd_data,
  output logic [AddressLength-1:0]                 rf_wr_addr,
  output logic                                     rf_wr_en,
  output logic [Registerlength-1:0]                rf_wr_data,
  output logic                                     done,
  output logic                                     err
);

  localparam int unsigned NL = Registerlength / elementSize;
  // Two spare bits so base + 3 never wraps back into the legal range.
  localparam int unsigned TW = AddressLength + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                    state, state_d;
  logic [TW-1:0]             tgt_q, tgt_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [Registerlength-1:0] beat_q, beat_d;
  logic [NL-1:0]             mask_q, mask_d;
  logic                      rd_act_q, rd_act_d;
  logic [AddressLength-1:0]  rd_addr_q, rd_addr_d;
  logic                      wr_en_d, done_d, err_d;
  logic [AddressLength-1:0]  wr_addr_d;
  logic [Registerlength-1:0] wr_data_d;
  logic [Registerlength-1:0] merged;

  logic          mask_full, mask_zero;
  logic [TW-1:0] new_tgt;
  logic [1:0]    new_cnt;
  logic          new_ovf, new_sup;

`ifdef VWB_LANE_MASK_EN
  assign mask_full  = &wb_mask;
  assign mask_zero  = ~|wb_mask;
  assign rf_rd_en   = {NL{rd_act_q}};
  assign rf_rd_addr = rd_addr_q;
`else
  assign mask_full  = 1'b1;
  assign mask_zero  = 1'b0;
  assign rf_rd_en   = '0;
  assign rf_rd_addr = '0;
  logic unused_rd;
  assign unused_rd = ^{rd_act_q, rd_addr_q};
`endif

  assign wb_ready = (state != READ) && !reset;

  // Target/counter of the beat being offered: a zero counter means a new burst.
  always_comb begin
    if (cnt_q == 2'd0) begin
      new_tgt = TW'(wb_addr);
      new_cnt = wb_len;
    end else begin
      new_tgt = tgt_q + TW'(1);
      new_cnt = cnt_q - 2'd1;
    end
    new_ovf = new_tgt > TW'(numRegisters - 1);
    new_sup = (new_tgt == '0) || new_ovf || mask_zero;
  end

  // Masked lanes from the captured beat, the rest from the register file.
  always_comb begin
    merged = rf_rd_data;
    for (int i = 0; i < NL; i++) begin
      if (mask_q[i]) merged[i*elementSize +: elementSize] = beat_q[i*elementSize +: elementSize];
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d   = state;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    beat_d    = beat_q;
    mask_d    = mask_q;
    rd_act_d  = 1'b0;
    rd_addr_d = '0;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state)
      READ: begin
        state_d   = WRITE;
        wr_en_d   = 1'b1;
        wr_addr_d = tgt_q[AddressLength-1:0];
        wr_data_d = merged;
        done_d    = (cnt_q == 2'd0);
      end
      default: begin
        if (wb_valid) begin
          tgt_d  = new_tgt;
          cnt_d  = new_cnt;
          beat_d = wb_data;
          mask_d = wb_mask;
          if (new_sup) begin
            state_d = WRITE;
            done_d  = (new_cnt == 2'd0);
            err_d   = new_ovf;
          end else if (mask_full) begin
            state_d   = WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = new_tgt[AddressLength-1:0];
            wr_data_d = wb_data;
            done_d    = (new_cnt == 2'd0);
          end else begin
            state_d   = READ;
            rd_act_d  = 1'b1;
            rd_addr_d = new_tgt[AddressLength-1:0];
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State, captured beat and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tgt_q      <= '0;
      cnt_q      <= '0;
      beat_q     <= '0;
      mask_q     <= '0;
      rd_act_q   <= 1'b0;
      rd_addr_q  <= '0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      mask_q     <= mask_d;
      rd_act_q   <= rd_act_d;
      rd_addr_q  <= rd_addr_d;
      rf_wr_en   <= wr_en_d;
      rf_wr_addr <= wr_addr_d;
      rf_wr_data <= wr_data_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

endmodule
